// File: rtl/vga_timing_pkg.sv
// Shared timing types, standard mode presets and bound helper for the VGA timing generator.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
    } vga_timing_t;

    typedef struct packed {
        logic [15:0] total;
        logic [15:0] sync_start;
        logic [15:0] sync_end;
    } vga_bounds_t;

    localparam vga_timing_t VGA_640x480 = '{
        h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
        v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33
    };

    localparam vga_timing_t SVGA_800x600 = '{
        h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
        v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23
    };

    // Sync window is [sync_start, sync_end); total is the full period in counts.
    function automatic vga_bounds_t vga_bounds(input int active, input int fp,
                                               input int sync, input int bp);
        vga_bounds_t b;
        b.total      = 16'(active + fp + sync + bp);
        b.sync_start = 16'(active + fp);
        b.sync_end   = 16'(active + fp + sync);
        return b;
    endfunction

endpackage

// File: rtl/vga_pix_prescaler.sv
// Divides clk into a one-clk pixel-advance strobe every CLK_DIV cycles while enabled.
module vga_pix_prescaler #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic pix_ce
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] cnt;

    // Free-running 0..CLK_DIV-1 phase counter, held at 0 while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    // Gated by reset so the strobe is quiet while reset is held, even with CLK_DIV=1.
    assign pix_ce = en && !reset && (cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing source: pixel prescaler, h/v counters and registered sync/blank decode.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          pix_ce,
    output logic          h_sync,
    output logic          v_sync,
    output logic          de,
    output logic          hblank,
    output logic          vblank,
    output logic [CW-1:0] x_pixel,
    output logic [CW-1:0] y_pixel,
    output logic          line_start,
    output logic          frame_start
);

    localparam vga_bounds_t H_BND = vga_bounds(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam vga_bounds_t V_BND = vga_bounds(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_BND.total - 16'd1);
    localparam logic [CW-1:0] V_LAST = CW'(V_BND.total - 16'd1);
    localparam logic [CW-1:0] H_SS   = CW'(H_BND.sync_start);
    localparam logic [CW-1:0] H_SE   = CW'(H_BND.sync_end);
    localparam logic [CW-1:0] V_SS   = CW'(V_BND.sync_start);
    localparam logic [CW-1:0] V_SE   = CW'(V_BND.sync_end);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
        $error("vga_timing_gen: timing parameters must all be non-zero");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be in 1..16");
    end
    if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_bad_cw
        $error("vga_timing_gen: CW too small for the line/frame totals");
    end

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          en_q;
    logic          new_pix;
    logic          show;

    vga_pix_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .pix_ce (pix_ce)
    );

    // Raster position: h advances per pixel, v per completed line; both clear while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
            end else begin
                h_cnt <= h_cnt + CW'(1);
            end
        end
    end

    // en_q keeps the decode alive for the one clk after en drops; new_pix marks a count not yet shown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q    <= 1'b0;
            new_pix <= 1'b1;
        end else begin
            en_q    <= en;
            new_pix <= !en || pix_ce;
        end
    end

    assign show = en || en_q;

    // Registered decode of the counters; idle (reset) values whenever the timing is stopped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_sync      <= ~HS_POL;
            v_sync      <= ~VS_POL;
            de          <= 1'b0;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            x_pixel     <= '0;
            y_pixel     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (show) begin
            h_sync      <= (h_cnt >= H_SS && h_cnt < H_SE) ? HS_POL : ~HS_POL;
            v_sync      <= (v_cnt >= V_SS && v_cnt < V_SE) ? VS_POL : ~VS_POL;
            de          <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
            hblank      <= (h_cnt >= H_ACT);
            vblank      <= (v_cnt >= V_ACT);
            x_pixel     <= h_cnt;
            y_pixel     <= v_cnt;
            line_start  <= new_pix && (h_cnt == '0);
            frame_start <= new_pix && (h_cnt == '0) && (v_cnt == '0);
        end else begin
            h_sync      <= ~HS_POL;
            v_sync      <= ~VS_POL;
            de          <= 1'b0;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            x_pixel     <= '0;
            y_pixel     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three configurations driven by a shared clk/reset/en, checked every
// cycle against a pixel-count reference model, plus a short vector table and corner sequences.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic en;

    logic [2:0] pce, hs, vs, de, hb, vb, ls, fs;
    logic [10:0] xp [3];
    logic [10:0] yp [3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // reference model state: en=1 edges since last clear, and en seen at the previous edge
    int rr = 0;
    bit enq = 1'b0;
    bit en_edge, valid;
    int s_show;

    int last_ls0 = -1, last_ls1 = -1, last_fs1 = -1, last_fs2 = -1, hs_run = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(.CLK_DIV(4)) u0 (
        .clk(clk), .reset(reset), .en(en), .pix_ce(pce[0]), .h_sync(hs[0]), .v_sync(vs[0]),
        .de(de[0]), .hblank(hb[0]), .vblank(vb[0]), .x_pixel(xp[0]), .y_pixel(yp[0]),
        .line_start(ls[0]), .frame_start(fs[0]));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                     .V_SYNC(1), .V_BP(1), .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1)) u1 (
        .clk(clk), .reset(reset), .en(en), .pix_ce(pce[1]), .h_sync(hs[1]), .v_sync(vs[1]),
        .de(de[1]), .hblank(hb[1]), .vblank(vb[1]), .x_pixel(xp[1]), .y_pixel(yp[1]),
        .line_start(ls[1]), .frame_start(fs[1]));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                     .V_SYNC(1), .V_BP(1), .CLK_DIV(3), .HS_POL(1'b0), .VS_POL(1'b1)) u2 (
        .clk(clk), .reset(reset), .en(en), .pix_ce(pce[2]), .h_sync(hs[2]), .v_sync(vs[2]),
        .de(de[2]), .hblank(hb[2]), .vblank(vb[2]), .x_pixel(xp[2]), .y_pixel(yp[2]),
        .line_start(ls[2]), .frame_start(fs[2]));

    function automatic void get_cfg(input int i, output int ha, output int hf, output int hw,
                                    output int hbp, output int va, output int vf, output int vw,
                                    output int vbp, output int d, output bit hp, output bit vp);
        if (i == 0) begin
            ha = 640; hf = 16; hw = 96; hbp = 48; va = 480; vf = 10; vw = 2; vbp = 33;
            d = 4; hp = 1'b0; vp = 1'b0;
        end else begin
            ha = 8; hf = 2; hw = 2; hbp = 2; va = 4; vf = 1; vw = 1; vbp = 1;
            d = (i == 1) ? 1 : 3;
            hp = (i == 1);
            vp = 1'b1;
        end
    endfunction

    // Expected outputs when the registers show pixel-clock tick number s of the current run.
    function automatic logic [29:0] exp_vec(input int i, input bit vld, input int s, input bit pce_e);
        int ha, hf, hw, hbp, va, vf, vw, vbp, d, ht, vt, n, h, v;
        bit hp, vp, fresh;
        logic hs_o, vs_o, de_o, hb_o, vb_o, ls_o, fs_o;
        get_cfg(i, ha, hf, hw, hbp, va, vf, vw, vbp, d, hp, vp);
        ht = ha + hf + hw + hbp;
        vt = va + vf + vw + vbp;
        h = 0; v = 0;
        hs_o = !hp; vs_o = !vp; de_o = 0; hb_o = 0; vb_o = 0; ls_o = 0; fs_o = 0;
        if (vld) begin
            n = s / d;
            h = n % ht;
            v = (n / ht) % vt;
            fresh = (s % d) == 0;
            hs_o = (h >= ha + hf && h < ha + hf + hw) ? hp : !hp;
            vs_o = (v >= va + vf && v < va + vf + vw) ? vp : !vp;
            de_o = (h < ha) && (v < va);
            hb_o = (h >= ha);
            vb_o = (v >= va);
            ls_o = fresh && (h == 0);
            fs_o = ls_o && (v == 0);
        end
        return {pce_e, hs_o, vs_o, de_o, hb_o, vb_o, ls_o, fs_o, 11'(h), 11'(v)};
    endfunction

    function automatic bit pce_exp(input int i);
        int ha, hf, hw, hbp, va, vf, vw, vbp, d;
        bit hp, vp;
        get_cfg(i, ha, hf, hw, hbp, va, vf, vw, vbp, d, hp, vp);
        return en && !reset && ((rr % d) == d - 1);
    endfunction

    function automatic logic [29:0] act_vec(input int i);
        return {pce[i], hs[i], vs[i], de[i], hb[i], vb[i], ls[i], fs[i], xp[i], yp[i]};
    endfunction

    task automatic check(input string name, input logic [29:0] got, input logic [29:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic clear_meas();
        last_ls0 = -1; last_ls1 = -1; last_fs1 = -1; last_fs2 = -1; hs_run = 0;
    endtask

    task automatic measure();
        if (!en_edge) begin
            clear_meas();
        end else begin
            if (ls[0]) begin
                if (last_ls0 >= 0) check("u0_line_period", 30'(cyc - last_ls0), 30'd3200);
                last_ls0 = cyc;
            end
            if (ls[1]) begin
                if (last_ls1 >= 0) check("u1_line_period", 30'(cyc - last_ls1), 30'd14);
                last_ls1 = cyc;
            end
            if (fs[1]) begin
                if (last_fs1 >= 0) check("u1_frame_period", 30'(cyc - last_fs1), 30'd98);
                last_fs1 = cyc;
            end
            if (fs[2]) begin
                if (last_fs2 >= 0) check("u2_frame_period", 30'(cyc - last_fs2), 30'd294);
                last_fs2 = cyc;
            end
            if (!hs[0]) begin
                hs_run++;
            end else if (hs_run > 0) begin
                check("u0_hsync_width", 30'(hs_run), 30'd384);
                hs_run = 0;
            end
        end
    endtask

    // One clk: model advances at the edge, outputs are compared at the following negedge.
    task automatic step();
        @(posedge clk);
        en_edge = en;
        s_show = rr;
        valid = en || enq;
        if (en) rr++;
        else rr = 0;
        enq = en;
        cyc++;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("u%0d_out", i), act_vec(i), exp_vec(i, valid, s_show, pce_exp(i)));
        measure();
    endtask

    // Asynchronous reset pulse between edges; outputs must be idle before any clock arrives.
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("u%0d_async_reset", i), act_vec(i), exp_vec(i, 1'b0, 0, 1'b0));
        rr = 0;
        enq = 1'b0;
        clear_meas();
        #2;
        reset = 1'b0;
    endtask

    typedef struct {
        bit en;
        int x;
        int y;
        bit ls;
        bit fs;
        bit de;
        bit hs;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int found;
        tbl[0] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 3, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0};

        reset = 1'b1;
        en = 1'b1;
        #12;
        for (int i = 0; i < 3; i++)
            check($sformatf("u%0d_reset_state", i), act_vec(i), exp_vec(i, 1'b0, 0, 1'b0));
        @(negedge clk);
        reset = 1'b0;
        rr = 0;
        enq = 1'b0;

        // cold start, en drop and restart on the small CLK_DIV=1 configuration
        for (int k = 0; k < 8; k++) begin
            en = tbl[k].en;
            step();
            check($sformatf("tbl_row%0d", k), 30'({xp[1], yp[1], ls[1], fs[1], de[1], hs[1]}),
                  30'({11'(tbl[k].x), 11'(tbl[k].y), tbl[k].ls, tbl[k].fs, tbl[k].de, tbl[k].hs}));
        end

        // free run covering two full default lines (line period, h_sync width)
        en = 1'b1;
        for (int k = 0; k < 7000; k++) step();

        // reset landing inside the default h_sync pulse
        found = 0;
        for (int k = 0; k < 4000 && found == 0; k++) begin
            step();
            if (xp[0] == 11'd700) found = 1;
        end
        check("wait_x700", 30'(found), 30'd1);
        check("u0_hs_in_sync", 30'(hs[0]), 30'd0);
        pulse_reset();

        // en dropped mid-line, held 50 clk, then restarted
        found = 0;
        for (int k = 0; k < 2000 && found == 0; k++) begin
            step();
            if (xp[0] == 11'd300) found = 1;
        end
        check("wait_x300", 30'(found), 30'd1);
        en = 1'b0;
        for (int k = 0; k < 50; k++) step();
        en = 1'b1;
        step();
        check("u0_restart_strobes", 30'({ls[0], fs[0]}), 30'd3);
        for (int k = 0; k < 3300; k++) step();

        // random run/stop pattern with the occasional asynchronous reset
        for (int k = 0; k < 3000; k++) begin
            en = ($urandom_range(0, 31) != 0);
            step();
            if ($urandom_range(0, 499) == 0) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
